calculadora_pipe: RTL and testbench

Parametrised, handshaked successor to the 4-bit calculadora.
- Datapath width is generic; mode field widened to 3 bits.
- Adds carry/overflow and zero flags, an internal accumulator, and an iterative multi-cycle multiply.
- Sits between the stimulus/tester driver and result consumer; registered outputs, one operation in flight at a time.

---
 rtl/calculadora_pipe.sv | 139 +++++++++++++
 tb/tb_calculadora_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/calculadora_pipe.sv
// Parametrised handshaked calculator: single-cycle ALU ops, accumulator, and
// an iterative shift-add multiply that holds the block busy for WIDTH cycles.
module calculadora_pipe #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       MODO,
    output logic [WIDTH-1:0] c,
    output logic             ovf,
    output logic             zero,
    output logic             out_valid
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_ACC = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_CLR = 3'b111;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t               state;
    logic [WIDTH-1:0]     acc;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   prod;

    logic [WIDTH-1:0]     alu_res;
    logic                 alu_ovf;
    logic [WIDTH:0]       add_sum;
    logic [WIDTH:0]       acc_sum;
    logic [2*WIDTH-1:0]   prod_next;

    always_comb begin
        add_sum = {1'b0, a} + {1'b0, b};
        acc_sum = {1'b0, acc} + {1'b0, a};
        alu_res = '0;
        alu_ovf = 1'b0;
        case (MODO)
            OP_ADD: begin
                alu_res = add_sum[WIDTH-1:0];
                alu_ovf = add_sum[WIDTH];
            end
            OP_SUB: begin
                alu_res = a - b;
                alu_ovf = (a < b);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_ACC: begin
                alu_res = acc_sum[WIDTH-1:0];
                alu_ovf = acc_sum[WIDTH];
            end
            default: begin
                alu_res = '0;
                alu_ovf = 1'b0;
            end
        endcase
    end

    // One multiplier bit per cycle; the multiplicand shifts left as the multiplier shifts right.
    always_comb begin
        prod_next = mplier[0] ? (prod + mcand) : prod;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            c         <= '0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        if (MODO == OP_MUL) begin
                            mcand    <= {{WIDTH{1'b0}}, a};
                            mplier   <= b;
                            prod     <= '0;
                            cnt      <= '0;
                            state    <= MUL;
                            in_ready <= 1'b0;
                        end else begin
                            c         <= alu_res;
                            ovf       <= alu_ovf;
                            zero      <= (alu_res == '0);
                            out_valid <= 1'b1;
                            if (MODO == OP_ACC) begin
                                acc <= alu_res;
                            end else if (MODO == OP_CLR) begin
                                acc <= '0;
                            end
                        end
                    end
                end
                MUL: begin
                    prod   <= prod_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        c         <= prod_next[WIDTH-1:0];
                        ovf       <= |prod_next[2*WIDTH-1:WIDTH];
                        zero      <= (prod_next[WIDTH-1:0] == '0);
                        out_valid <= 1'b1;
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calculadora_pipe.sv
// Self-checking bench for calculadora_pipe: directed scenarios plus randomized
// operations on WIDTH=4, and multiply checks on a WIDTH=8 instance.
module tb_calculadora_pipe;

    logic       clk = 1'b0;
    logic       rst;

    logic       in_valid4, in_ready4, ovf4, zero4, out_valid4;
    logic [3:0] a4, b4, c4;
    logic [2:0] mode4;

    logic       in_valid8, in_ready8, ovf8, zero8, out_valid8;
    logic [7:0] a8, b8, c8;
    logic [2:0] mode8;

    int checks = 0;
    int errors = 0;
    int acc4 = 0;
    int acc8 = 0;

    calculadora_pipe #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .MODO(mode4), .c(c4), .ovf(ovf4), .zero(zero4),
        .out_valid(out_valid4)
    );

    calculadora_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .MODO(mode8), .c(c8), .ovf(ovf8), .zero(zero8),
        .out_valid(out_valid8)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference behaviour written straight from the arithmetic definition of each mode.
    task automatic refModel(input int m, input int x, input int y, input int w,
                            inout int accm, output int ec, output int eovf);
        int md, s;
        md = 1 << w;
        ec = 0;
        eovf = 0;
        case (m)
            0: begin s = x + y; ec = s % md; eovf = (s >= md); end
            1: begin ec = (x - y + md) % md; eovf = (x < y); end
            2: ec = x & y;
            3: ec = x | y;
            4: ec = x ^ y;
            5: begin s = accm + x; accm = s % md; ec = accm; eovf = (s >= md); end
            6: begin s = x * y; ec = s % md; eovf = (s >= md); end
            default: begin accm = 0; ec = 0; eovf = 0; end
        endcase
    endtask

    // Drive one operation into the WIDTH=4 instance across one rising edge.
    task automatic applyStimulus(input int m, input int x, input int y);
        in_valid4 = 1'b1;
        mode4 = 3'(m);
        a4 = 4'(x);
        b4 = 4'(y);
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
    endtask

    task automatic doSingle(input string tag, input int m, input int x, input int y);
        int ec, eovf;
        refModel(m, x, y, 4, acc4, ec, eovf);
        checkOutput({tag, "_ready"}, in_ready4, 1);
        applyStimulus(m, x, y);
        checkOutput({tag, "_valid"}, out_valid4, 1);
        checkOutput({tag, "_c"}, c4, ec);
        checkOutput({tag, "_ovf"}, ovf4, eovf);
        checkOutput({tag, "_zero"}, zero4, (ec == 0));
    endtask

    task automatic doMul(input string tag, input int x, input int y);
        int ec, eovf, n;
        bit got;
        refModel(6, x, y, 4, acc4, ec, eovf);
        checkOutput({tag, "_ready"}, in_ready4, 1);
        applyStimulus(6, x, y);
        n = 0;
        got = 0;
        while (!got && n < 12) begin
            checkOutput({tag, "_busy"}, in_ready4, 0);
            checkOutput({tag, "_novalid"}, out_valid4, 0);
            in_valid4 = 1'b1;
            mode4 = 3'($urandom_range(0, 7));
            a4 = 4'($urandom_range(0, 15));
            b4 = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
            n++;
            if (out_valid4) got = 1;
        end
        in_valid4 = 1'b0;
        checkOutput({tag, "_done"}, got, 1);
        checkOutput({tag, "_latency"}, n, 4);
        checkOutput({tag, "_c"}, c4, ec);
        checkOutput({tag, "_ovf"}, ovf4, eovf);
        checkOutput({tag, "_zero"}, zero4, (ec == 0));
        checkOutput({tag, "_ready_after"}, in_ready4, 1);
        @(posedge clk);
        #1;
        checkOutput({tag, "_pulse"}, out_valid4, 0);
        checkOutput({tag, "_hold_c"}, c4, ec);
    endtask

    task automatic doMul8(input string tag, input int x, input int y);
        int ec, eovf, n;
        bit got;
        refModel(6, x, y, 8, acc8, ec, eovf);
        checkOutput({tag, "_ready"}, in_ready8, 1);
        in_valid8 = 1'b1;
        mode8 = 3'd6;
        a8 = 8'(x);
        b8 = 8'(y);
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        a8 = 8'($urandom_range(0, 255));
        b8 = 8'($urandom_range(0, 255));
        n = 0;
        got = 0;
        while (!got && n < 24) begin
            checkOutput({tag, "_busy"}, in_ready8, 0);
            @(posedge clk);
            #1;
            n++;
            if (out_valid8) got = 1;
        end
        checkOutput({tag, "_done"}, got, 1);
        checkOutput({tag, "_latency"}, n, 8);
        checkOutput({tag, "_c"}, c8, ec);
        checkOutput({tag, "_ovf"}, ovf8, eovf);
        checkOutput({tag, "_zero"}, zero8, (ec == 0));
    endtask

    initial begin
        int m, x, y, n, ec, eovf;
        bit seen;

        rst = 1'b1;
        in_valid4 = 1'b0; mode4 = '0; a4 = '0; b4 = '0;
        in_valid8 = 1'b0; mode8 = '0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_c", c4, 0);
        checkOutput("rst_ovf", ovf4, 0);
        checkOutput("rst_zero", zero4, 0);
        checkOutput("rst_valid", out_valid4, 0);
        checkOutput("rst_ready", in_ready4, 1);
        rst = 1'b0;

        doSingle("add_9_8", 0, 9, 8);
        doSingle("sub_3_5", 1, 3, 5);
        doSingle("sub_5_5", 1, 5, 5);

        // Asynchronous reset in the middle of a cycle must clear outputs without a clock edge.
        doSingle("add_pre", 0, 2, 3);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_c", c4, 0);
        checkOutput("arst_ovf", ovf4, 0);
        checkOutput("arst_zero", zero4, 0);
        checkOutput("arst_valid", out_valid4, 0);
        checkOutput("arst_ready", in_ready4, 1);
        acc4 = 0;
        acc8 = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        doMul("mul_7_3", 7, 3);

        doSingle("clr", 7, 0, 0);
        doSingle("acc_6", 5, 6, 0);
        doSingle("acc_12", 5, 12, 0);
        doSingle("and_f_3", 2, 15, 3);
        doSingle("acc_4", 5, 4, 0);

        doSingle("add_f_1", 0, 15, 1);
        doSingle("zero_xor", 4, 0, 0);
        doMul("mul_by_0", 9, 0);

        // Reset during a multiply: no result may appear and the accumulator is cleared.
        doSingle("acc_pre", 5, 3, 0);
        applyStimulus(6, 5, 5);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mrst_valid", out_valid4, 0);
        checkOutput("mrst_ready", in_ready4, 1);
        acc4 = 0;
        acc8 = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (out_valid4) seen = 1;
        end
        checkOutput("mrst_no_result", seen, 0);
        checkOutput("mrst_ready_after", in_ready4, 1);
        doSingle("add_1_1", 0, 1, 1);
        doSingle("acc_after_rst", 5, 5, 0);

        for (int i = 0; i < 40; i++) begin
            m = $urandom_range(0, 7);
            x = $urandom_range(0, 15);
            y = $urandom_range(0, 15);
            if ($urandom_range(0, 7) == 0) begin
                x = 0;
                y = 0;
            end
            if (m == 6) doMul("rnd_mul", x, y);
            else doSingle("rnd_op", m, x, y);
        end

        doMul8("mul8_15_17", 15, 17);
        doMul8("mul8_16_16", 16, 16);
        for (int i = 0; i < 4; i++) begin
            doMul8("mul8_rnd", $urandom_range(0, 255), $urandom_range(0, 255));
        end

        x = $urandom_range(0, 255);
        y = $urandom_range(0, 255);
        refModel(0, x, y, 8, acc8, ec, eovf);
        in_valid8 = 1'b1;
        mode8 = 3'd0;
        a8 = 8'(x);
        b8 = 8'(y);
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        checkOutput("add8_valid", out_valid8, 1);
        checkOutput("add8_c", c8, ec);
        checkOutput("add8_ovf", ovf8, eovf);
        n = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
